// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared encodings for the MMU table-walk memory responder
package mmu_pkg;

  typedef enum logic [1:0] {
    PL_RESP_STT_IDLE  = 2'h0,
    PL_RESP_STT_ISSUE = 2'h1,
    PL_RESP_STT_WAIT  = 2'h2,
    PL_RESP_STT_DRAIN = 2'h3
  } resp_state_t;

  localparam logic [31:0] PL_ALIGN8_MASK = 32'hFFFF_FFF8;

  function automatic logic [31:0] align8(input logic [31:0] addr);
    return addr & PL_ALIGN8_MASK;
  endfunction

endpackage

// File: rtl/mmu_table_mem_responder_if.sv
// rtl/mmu_table_mem_responder_if.sv - requester and memory-bus signals of the responder
interface mmu_table_mem_responder_if;

  logic        iREQ_VALID;
  logic        oREQ_LOCK;
  logic [31:0] iREQ_ADDR;
  logic        oRD_VALID;
  logic [63:0] oRD_DATA;
  logic        oBUS_REQ;
  logic        iBUS_BUSY;
  logic [31:0] oBUS_ADDR;
  logic        iBUS_VALID;
  logic [63:0] iBUS_DATA;

  modport slave (
    input  iREQ_VALID, iREQ_ADDR, iBUS_BUSY, iBUS_VALID, iBUS_DATA,
    output oREQ_LOCK, oRD_VALID, oRD_DATA, oBUS_REQ, oBUS_ADDR
  );

  modport master (
    output iREQ_VALID, iREQ_ADDR, iBUS_BUSY, iBUS_VALID, iBUS_DATA,
    input  oREQ_LOCK, oRD_VALID, oRD_DATA, oBUS_REQ, oBUS_ADDR
  );

endinterface

// File: rtl/mmu_req_fifo.sv
// rtl/mmu_req_fifo.sv - P_DEPTH x 32 request queue with push/pop/flush
module mmu_req_fifo #(
  parameter  int P_DEPTH = 2,
  localparam int PW      = $clog2(P_DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          iCLOCK,
  input  logic          inRESET,
  input  logic          iFLUSH,
  input  logic          iPUSH,
  input  logic          iPOP,
  input  logic [31:0]   iDATA,
  output logic [31:0]   oDATA,
  output logic [CW-1:0] oCOUNT,
  output logic          oEMPTY
);

  logic [31:0]   mem [P_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(P_DEPTH));
  assign oEMPTY  = (count == '0);
  assign oCOUNT  = count;
  assign oDATA   = mem[rd_ptr];
  assign do_push = iPUSH && !full && !iFLUSH;
  assign do_pop  = iPOP && !oEMPTY && !iFLUSH;

  always_ff @(posedge iCLOCK) begin
    if (do_push) begin
      mem[wr_ptr] <= iDATA;
    end
  end

  // Pointers wrap naturally because P_DEPTH is a power of two.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iFLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmu_table_mem_responder.sv
// rtl/mmu_table_mem_responder.sv - queues MMU table reads and serves them one at a time on the memory bus
module mmu_table_mem_responder
  import mmu_pkg::*;
#(
  parameter int P_DEPTH = 2
) (
  input logic                        iCLOCK,
  input logic                        inRESET,
  input logic                        iRESET_SYNC,
  mmu_table_mem_responder_if.slave   bus
);

  localparam int CW = $clog2(P_DEPTH) + 1;

  resp_state_t   state;
  resp_state_t   state_nxt;
  logic [31:0]   b_issue_addr;
  logic          b_rd_valid;
  logic [63:0]   b_rd_data;
  logic [31:0]   q_head;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          lock;
  logic          push;
  logic          pop;
  logic          resp_hit;

  assign lock     = (q_count == CW'(P_DEPTH)) || (state == PL_RESP_STT_DRAIN);
  assign push     = bus.iREQ_VALID && !lock;
  assign pop      = (state == PL_RESP_STT_IDLE) && !q_empty && !iRESET_SYNC;
  assign resp_hit = (state == PL_RESP_STT_WAIT) && bus.iBUS_VALID;

  mmu_req_fifo #(.P_DEPTH(P_DEPTH)) u_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .iFLUSH  (iRESET_SYNC),
    .iPUSH   (push),
    .iPOP    (pop),
    .iDATA   (bus.iREQ_ADDR),
    .oDATA   (q_head),
    .oCOUNT  (q_count),
    .oEMPTY  (q_empty)
  );

  always_comb begin
    state_nxt = state;
    if (iRESET_SYNC) begin
      // A flush that lands while the bus still owes a beat must swallow it.
      if ((state == PL_RESP_STT_WAIT && !bus.iBUS_VALID) ||
          (state == PL_RESP_STT_ISSUE && !bus.iBUS_BUSY)) begin
        state_nxt = PL_RESP_STT_DRAIN;
      end else begin
        state_nxt = PL_RESP_STT_IDLE;
      end
    end else begin
      case (state)
        PL_RESP_STT_IDLE:  if (!q_empty)         state_nxt = PL_RESP_STT_ISSUE;
        PL_RESP_STT_ISSUE: if (!bus.iBUS_BUSY)   state_nxt = PL_RESP_STT_WAIT;
        PL_RESP_STT_WAIT:  if (bus.iBUS_VALID)   state_nxt = PL_RESP_STT_IDLE;
        PL_RESP_STT_DRAIN: if (bus.iBUS_VALID)   state_nxt = PL_RESP_STT_IDLE;
        default:                                 state_nxt = PL_RESP_STT_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state        <= PL_RESP_STT_IDLE;
      b_issue_addr <= 32'h0;
      b_rd_valid   <= 1'b0;
      b_rd_data    <= 64'h0;
    end else begin
      state      <= state_nxt;
      b_rd_valid <= resp_hit && !iRESET_SYNC;
      if (pop) begin
        b_issue_addr <= align8(q_head);
      end
      if (resp_hit && !iRESET_SYNC) begin
        b_rd_data <= bus.iBUS_DATA;
      end
    end
  end

  assign bus.oREQ_LOCK = lock;
  assign bus.oRD_VALID = b_rd_valid;
  assign bus.oRD_DATA  = b_rd_data;
  assign bus.oBUS_REQ  = (state == PL_RESP_STT_ISSUE);
  assign bus.oBUS_ADDR = b_issue_addr;

endmodule

// File: tb/tb_mmu_table_mem_responder.sv
// tb/tb_mmu_table_mem_responder.sv - directed scoreboard bench for mmu_table_mem_responder
module tb_mmu_table_mem_responder;

  logic clk;
  logic rst_n;
  logic flush;

  mmu_table_mem_responder_if bus_if ();

  mmu_table_mem_responder #(.P_DEPTH(2)) dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (flush),
    .bus         (bus_if)
  );

  int          n_vec;
  int          n_err;
  logic [63:0] exp_data [$];
  logic [31:0] exp_addr [$];
  bit          auto_bus;
  bit          pend;
  logic [31:0] pend_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] bus_word(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 64'hDEAD_BEEF_0123_4567 : {a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input bit resp, input bit issued);
    int budget;
    budget = 50;
    bus_if.iREQ_VALID = 1'b1;
    bus_if.iREQ_ADDR  = a;
    while (bus_if.oREQ_LOCK && budget > 0) begin
      tick();
      budget--;
    end
    chk("send_accept_lock", {63'h0, bus_if.oREQ_LOCK}, 64'h0);
    if (issued) exp_addr.push_back(a & 32'hFFFF_FFF8);
    if (resp)   exp_data.push_back(bus_word(a & 32'hFFFF_FFF8));
    tick();
    bus_if.iREQ_VALID = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    while (exp_data.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_pending", 64'(exp_data.size()), 64'h0);
  endtask

  // Bus model: one-cycle latency answer to every accepted request while enabled.
  always @(negedge clk) begin
    if (auto_bus) begin
      bus_if.iBUS_VALID = 1'b0;
      if (pend) begin
        bus_if.iBUS_VALID = 1'b1;
        bus_if.iBUS_DATA  = bus_word(pend_addr);
        pend = 1'b0;
      end
      if (rst_n && bus_if.oBUS_REQ && !bus_if.iBUS_BUSY) begin
        pend      = 1'b1;
        pend_addr = bus_if.oBUS_ADDR;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.oRD_VALID) begin
        chk("rd_expected", {63'h0, exp_data.size() != 0}, 64'h1);
        if (exp_data.size() != 0) chk("rd_data", bus_if.oRD_DATA, exp_data.pop_front());
      end
      if (bus_if.oBUS_REQ && !bus_if.iBUS_BUSY) begin
        chk("bus_expected", {63'h0, exp_addr.size() != 0}, 64'h1);
        if (exp_addr.size() != 0) chk("bus_addr", 64'(bus_if.oBUS_ADDR), 64'(exp_addr.pop_front()));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    auto_bus = 1'b1;
    pend = 1'b0;
    pend_addr = 32'h0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus_if.iREQ_VALID = 1'b0;
    bus_if.iREQ_ADDR  = 32'h0;
    bus_if.iBUS_BUSY  = 1'b0;
    bus_if.iBUS_VALID = 1'b0;
    bus_if.iBUS_DATA  = 64'h0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_lock",    {63'h0, bus_if.oREQ_LOCK}, 64'h0);
    chk("rst_rdvalid", {63'h0, bus_if.oRD_VALID}, 64'h0);
    chk("rst_rddata",  bus_if.oRD_DATA, 64'h0);
    chk("rst_busreq",  {63'h0, bus_if.oBUS_REQ}, 64'h0);
    chk("rst_busaddr", 64'(bus_if.oBUS_ADDR), 64'h0);

    // Single read with minimum latency.
    send(32'h0000_1004, 1'b1, 1'b1);
    tick();
    chk("lat_busreq",  {63'h0, bus_if.oBUS_REQ}, 64'h1);
    chk("lat_busaddr", 64'(bus_if.oBUS_ADDR), 64'h0000_1000);
    tick();
    chk("lat_rd_c3", {63'h0, bus_if.oRD_VALID}, 64'h0);
    tick();
    chk("lat_rd_c4", {63'h0, bus_if.oRD_VALID}, 64'h1);
    chk("lat_data",  bus_if.oRD_DATA, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("lat_pulse", {63'h0, bus_if.oRD_VALID}, 64'h0);

    // Back-pressure and bus stall: one read stuck in ISSUE, queue fills.
    bus_if.iBUS_BUSY = 1'b1;
    send(32'h0000_2000, 1'b1, 1'b1);
    send(32'h0000_2008, 1'b1, 1'b1);
    send(32'h0000_2010, 1'b1, 1'b1);
    bus_if.iREQ_VALID = 1'b1;
    bus_if.iREQ_ADDR  = 32'h0000_2018;
    chk("bp_lock", {63'h0, bus_if.oREQ_LOCK}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  {63'h0, bus_if.oBUS_REQ}, 64'h1);
      chk("stall_addr", 64'(bus_if.oBUS_ADDR), 64'h0000_2000);
      tick();
    end
    bus_if.iBUS_BUSY = 1'b0;
    send(32'h0000_2018, 1'b1, 1'b1);
    wait_drain(200);

    // Flush while a read is outstanding with one entry queued.
    auto_bus = 1'b0;
    repeat (2) tick();
    send(32'h0000_3000, 1'b0, 1'b1);
    send(32'h0000_3008, 1'b0, 1'b0);
    chk("fl_busreq", {63'h0, bus_if.oBUS_REQ}, 64'h1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_count", 64'(dut.q_count), 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_lock", {63'h0, bus_if.oREQ_LOCK}, 64'h1);
      tick();
    end
    bus_if.iBUS_VALID = 1'b1;
    bus_if.iBUS_DATA  = 64'h1111_2222_3333_4444;
    tick();
    bus_if.iBUS_VALID = 1'b0;
    chk("fl_unlock", {63'h0, bus_if.oREQ_LOCK}, 64'h0);
    repeat (3) tick();
    chk("fl_noreq", {63'h0, bus_if.oBUS_REQ}, 64'h0);
    chk("fl_norsp", {63'h0, bus_if.oRD_VALID}, 64'h0);

    // Asynchronous reset while waiting on the bus.
    send(32'h0000_4000, 1'b0, 1'b1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_lock",    {63'h0, bus_if.oREQ_LOCK}, 64'h0);
    chk("ar_rdvalid", {63'h0, bus_if.oRD_VALID}, 64'h0);
    chk("ar_rddata",  bus_if.oRD_DATA, 64'h0);
    chk("ar_busreq",  {63'h0, bus_if.oBUS_REQ}, 64'h0);
    chk("ar_busaddr", 64'(bus_if.oBUS_ADDR), 64'h0);
    tick();
    rst_n = 1'b1;
    bus_if.iBUS_VALID = 1'b1;
    bus_if.iBUS_DATA  = 64'h5555_6666_7777_8888;
    tick();
    bus_if.iBUS_VALID = 1'b0;
    tick();
    chk("ar_norsp", {63'h0, bus_if.oRD_VALID}, 64'h0);
    chk("ar_noreq", {63'h0, bus_if.oBUS_REQ}, 64'h0);

    // Push and pop in the same cycle at count 1.
    auto_bus = 1'b1;
    send(32'h0000_5000, 1'b1, 1'b1);
    send(32'h0000_5008, 1'b1, 1'b1);
    chk("pp_count", 64'(dut.q_count), 64'h1);
    send(32'h0000_5010, 1'b1, 1'b1);
    wait_drain(200);
    repeat (3) tick();
    chk("end_addr_q", 64'(exp_addr.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
